gcd_lcm_unit: RTL and testbench

GCD_LCM_UNIT -- requirements
Module: gcd_lcm_unit

---
 rtl/gcd_lcm_pkg.sv | 14 +
 rtl/seq_divider.sv | 52 +++++
 rtl/gcd_lcm_unit.sv | 131 +++++++++++++
 tb/tb_gcd_lcm_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM unit.
package gcd_lcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_LCM = 1'b1;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle over N cycles.
// The *_c outputs are the values produced by the step currently in progress.
module seq_divider #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient_c,
    output logic [N-1:0] remainder_c,
    output logic         ready_c
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic [N:0]    shifted;
    logic          ge;

    // One restoring step; the partial remainder always stays below the divisor.
    always_comb begin
        shifted     = {rem, quo[N-1]};
        ge          = (shifted >= {1'b0, dvs});
        quotient_c  = {quo[N-2:0], ge};
        remainder_c = ge ? (shifted[N-1:0] - dvs) : shifted[N-1:0];
        ready_c     = (cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= CW'(N);
        end else if (cnt != '0) begin
            rem <= remainder_c;
            quo <= quotient_c;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/gcd_lcm_unit.sv
// Sequential GCD (repeated subtraction) / LCM (a*b divided by the GCD) unit.
module gcd_lcm_unit
    import gcd_lcm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero_in
);

    localparam int unsigned N = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             m;
    logic [N-1:0]     p;
    logic             zf;
    logic [WIDTH-1:0] g;
    logic             xy_zero;
    logic             need_div;

    logic             latch_en;
    logic             sub_en;
    logic             gcd_done;
    logic             div_load;
    logic             div_done;

    logic [N-1:0]     div_q;
    logic [N-1:0]     div_rem;
    logic             div_ready;

    assign g        = x | y;
    assign xy_zero  = (x == '0) || (y == '0);
    assign need_div = (m == MODE_LCM) && (g != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (xy_zero) state_next = need_div ? DIV : DONE;
            DIV:     if (div_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        latch_en = 1'b0;
        sub_en   = 1'b0;
        gcd_done = 1'b0;
        div_load = 1'b0;
        div_done = 1'b0;
        case (state)
            IDLE: latch_en = start;
            CALC: begin
                sub_en   = !xy_zero;
                gcd_done = xy_zero && !need_div;
                div_load = xy_zero && need_div;
            end
            DIV:     div_done = div_ready;
            default: ;
        endcase
    end

    // Operand/subtractor datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            m       <= MODE_GCD;
            p       <= '0;
            zf      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero_in <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (latch_en) begin
                x  <= a;
                y  <= b;
                m  <= mode;
                p  <= N'(a) * N'(b);
                zf <= (a == '0) || (b == '0);
            end
            if (sub_en) begin
                if (x >= y) x <= x - y;
                else        y <= y - x;
            end
            if (gcd_done) begin
                result  <= N'(g);
                zero_in <= zf;
            end
            if (div_done) begin
                result  <= div_q;
                zero_in <= zf;
            end
        end
    end

    seq_divider #(.N(N)) u_div (
        .clk         (clk),
        .rst         (rst),
        .load        (div_load),
        .dividend    (p),
        .divisor     (N'(g)),
        .quotient_c  (div_q),
        .remainder_c (div_rem),
        .ready_c     (div_ready)
    );

    // a*b is always a multiple of gcd(a,b), so the division must be exact.
    exact_div_a: assert property (@(posedge clk) disable iff (rst) div_done |-> (div_rem == '0));

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Bench for gcd_lcm_unit: Euclid-based reference model checked every cycle, plus directed cases.
module tb_gcd_lcm_unit;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           zero_in;

    int n_checks = 0;
    int n_pass   = 0;

    gcd_lcm_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero_in (zero_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic longint m_gcd(input longint x0, input longint y0);
        longint x = x0;
        longint y = y0;
        longint r;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x;
    endfunction

    // Subtraction count of the subtractive algorithm = sum of Euclid quotients.
    function automatic int m_subs(input longint x0, input longint y0);
        longint hi = (x0 > y0) ? x0 : y0;
        longint lo = (x0 > y0) ? y0 : x0;
        longint r;
        int s = 0;
        while (lo != 0) begin
            s  += int'(hi / lo);
            r  = hi % lo;
            hi = lo;
            lo = r;
        end
        return s;
    endfunction

    function automatic int m_latency(input logic md, input longint x, input longint y);
        longint g = m_gcd(x, y);
        int l = m_subs(x, y) + 2;
        if (md && g != 0) l += 2 * W;
        return l;
    endfunction

    function automatic longint m_result(input logic md, input longint x, input longint y);
        longint g = m_gcd(x, y);
        if (!md) return g;
        if (g == 0) return 0;
        return (x * y) / g;
    endfunction

    // Transaction-level model: t counts cycles since acceptance, done at t == lat.
    logic   m_act  = 1'b0;
    int     m_t    = 0;
    int     m_lat  = 0;
    longint m_res  = 0;
    logic   m_zero = 1'b0;
    longint p_res  = 0;
    logic   p_zero = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            m_lat  <= 0;
            m_res  <= 0;
            m_zero <= 1'b0;
            p_res  <= 0;
            p_zero <= 1'b0;
        end else if (m_act) begin
            if (m_t == m_lat) m_act <= 1'b0;
            else begin
                m_t <= m_t + 1;
                if (m_t + 1 == m_lat) begin
                    m_res  <= p_res;
                    m_zero <= p_zero;
                end
            end
        end else if (start) begin
            m_act  <= 1'b1;
            m_t    <= 1;
            m_lat  <= m_latency(mode, longint'(a), longint'(b));
            p_res  <= m_result(mode, longint'(a), longint'(b));
            p_zero <= (a == '0) || (b == '0);
        end
    end

    always @(negedge clk) begin
        chk("busy",    busy,    m_act);
        chk("done",    done,    m_act && (m_t == m_lat));
        chk("result",  result,  m_res);
        chk("zero_in", zero_in, m_zero);
    end

    // Issue one operation from a negedge; optionally keep start high with junk operands.
    task automatic run(input logic md, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input longint exp_res, input logic exp_zero, input int exp_cyc,
                       input int hold);
        int k;
        start = 1'b1;
        mode  = md;
        a     = aa;
        b     = bb;
        @(negedge clk);
        k = 1;
        while (!done && k < 400) begin
            if (k <= hold) begin
                start = 1'b1;
                mode  = ~md;
                a     = aa ^ 8'h5A;
                b     = bb + 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("latency", k, exp_cyc);
        chk("res_lit", result, exp_res);
        chk("zero_lit", zero_in, exp_zero);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero_in, 0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 8'd12,  8'd8,   4,     1'b0, 5,   0);
        run(1'b1, 8'd4,   8'd6,   12,    1'b0, 21,  0);
        run(1'b1, 8'd255, 8'd254, 64770, 1'b0, 273, 0);
        run(1'b0, 8'd0,   8'd9,   9,     1'b1, 2,   0);
        run(1'b1, 8'd0,   8'd0,   0,     1'b1, 2,   0);
        run(1'b1, 8'd0,   8'd5,   0,     1'b1, 18,  0);
        run(1'b0, 8'd255, 8'd255, 255,   1'b0, 3,   0);
        run(1'b1, 8'd1,   8'd255, 255,   1'b0, 273, 0);
        run(1'b1, 8'd6,   8'd4,   12,    1'b0, 21,  3);

        // Abort in the middle of DIV.
        start = 1'b1;
        mode  = 1'b1;
        a     = 8'd4;
        b     = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 8'd100, 8'd75, 25, 1'b0, 6, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
